// File: rtl/mj32_lsu.sv
// rtl/mj32_lsu.sv - MJ32 handshaked multi-cycle load/store unit
//
// Accepts one load/store from the execute stage and runs it on a
// request/grant/response bus. It builds byte enables and lane-replicated
// store data, and extracts and extends load data. Illegal (and, optionally,
// misaligned) accesses complete with an error and no bus activity. Bus
// transactions that run too long are abandoned.
//
// Parameters:
//   ADDR_W          byte-address width (>= 3)
//   TIMEOUT_CYCLES  max cycles in REQ+WAIT before abort, 0 disables
// Optional feature macro:
//   MJ32_LSU_MISALIGN_TRAP_EN  misaligned half/word accesses raise an error
//                              instead of having their low address bits ignored
// Ports:
//   clk_i, rst_ni                  clock (rising edge), async active-low reset
//   req_valid_i / req_ready_o      core request handshake
//   req_store_i, req_funct3_i      access kind and RV32I width/sign code
//   req_addr_i, req_wdata_i        byte address and store data
//   req_rd_i                       load destination, echoed on resp_rd_o
//   resp_valid_o                   one-cycle completion pulse
//   resp_rdata_o, resp_rd_o        extended load data, echoed rd
//   resp_err_o                     illegal, misaligned or timed out
//   mem_req_o / mem_gnt_i          bus request held until grant
//   mem_we_o, mem_addr_o           write strobe, word-aligned address
//   mem_be_o, mem_wdata_o          byte enables, lane-replicated store data
//   mem_rvalid_i, mem_rdata_i      read data / write acknowledge

module mj32_lsu #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_store_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    input  logic [4:0]        req_rd_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_rdata_o,
    output logic [4:0]        resp_rd_o,
    output logic              resp_err_o,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t            state_q;
    logic              ready_q, resp_valid_q, resp_err_q;
    logic [31:0]       resp_rdata_q;
    logic [4:0]        resp_rd_q, rd_q;
    logic              mem_req_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [3:0]        mem_be_q;
    logic [31:0]       mem_wdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        sz_q, off_q;
    logic              uns_q, store_q;

    // Request decode: funct3[1:0] is the size, funct3[2] the unsigned flag.
    logic [1:0]  sz_d, off_d;
    logic        legal_d, misalign_d, timeout_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, shifted_d, load_d;

    assign sz_d = req_funct3_i[1:0];

    always_comb begin
        legal_d = 1'b0;
        case (req_funct3_i)
            3'b000, 3'b001, 3'b010: legal_d = 1'b1;
            3'b100, 3'b101:         legal_d = !req_store_i;
            default:                legal_d = 1'b0;
        endcase
        misalign_d = 1'b0;
`ifdef MJ32_LSU_MISALIGN_TRAP_EN
        if (sz_d == 2'b01)      misalign_d = req_addr_i[0];
        else if (sz_d == 2'b10) misalign_d = |req_addr_i[1:0];
`endif
        // Effective lane offset: address bits below the access size are dropped.
        case (sz_d)
            2'b00:   off_d = req_addr_i[1:0];
            2'b01:   off_d = {req_addr_i[1], 1'b0};
            default: off_d = 2'b00;
        endcase
        case (sz_d)
            2'b00: begin be_d = 4'b0001 << off_d; wdata_d = {4{req_wdata_i[7:0]}};  end
            2'b01: begin be_d = 4'b0011 << off_d; wdata_d = {2{req_wdata_i[15:0]}}; end
            default: begin be_d = 4'b1111;        wdata_d = req_wdata_i;            end
        endcase
    end

    always_comb begin
        shifted_d = mem_rdata_i >> {off_q, 3'b000};
        case (sz_q)
            2'b00:   load_d = uns_q ? {24'b0, shifted_d[7:0]}
                                    : {{24{shifted_d[7]}}, shifted_d[7:0]};
            2'b01:   load_d = uns_q ? {16'b0, shifted_d[15:0]}
                                    : {{16{shifted_d[15]}}, shifted_d[15:0]};
            default: load_d = shifted_d;
        endcase
    end

    // Counter value in this cycle is the number of REQ/WAIT cycles already spent.
    assign timeout_d = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            resp_rd_q    <= '0;
            rd_q         <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            cnt_q        <= '0;
            sz_q         <= '0;
            off_q        <= '0;
            uns_q        <= 1'b0;
            store_q      <= 1'b0;
        end else begin
            // Response fields only carry data during the DONE pulse.
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            resp_rd_q    <= '0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        ready_q <= 1'b0;
                        rd_q    <= req_rd_i;
                        sz_q    <= sz_d;
                        off_q   <= off_d;
                        uns_q   <= req_funct3_i[2];
                        store_q <= req_store_i;
                        if (!legal_d || misalign_d) begin
                            state_q      <= S_DONE;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rd_q    <= req_rd_i;
                        end else begin
                            state_q     <= S_REQ;
                            cnt_q       <= '0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= req_store_i;
                            mem_addr_q  <= {req_addr_i[ADDR_W-1:2], 2'b00};
                            mem_be_q    <= be_d;
                            mem_wdata_q <= wdata_d;
                        end
                    end
                end
                S_REQ: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (timeout_d || mem_gnt_i) begin
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_be_q    <= '0;
                        mem_wdata_q <= '0;
                    end
                    // A grant in the terminal cycle still loses to the timeout.
                    if (timeout_d) begin
                        state_q      <= S_DONE;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rd_q    <= rd_q;
                    end else if (mem_gnt_i) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // A response in the terminal cycle wins over the timeout.
                    if (mem_rvalid_i) begin
                        state_q      <= S_DONE;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= store_q ? 32'b0 : load_d;
                        resp_rd_q    <= rd_q;
                    end else if (timeout_d) begin
                        state_q      <= S_DONE;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rd_q    <= rd_q;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o  = ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_err_o   = resp_err_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_rd_o    = resp_rd_q;
    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_be_o     = mem_be_q;
    assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: doc/mj32_lsu.md
# mj32_lsu

Parametrised load/store unit for the MJ32 core family. It replaces the combinational load/store path with a handshaked, multi-cycle engine between the core's execute stage and a request/grant/response data bus. It generates byte enables and lane-aligned store data, and sign- or zero-extends load data. It detects illegal and misaligned accesses and abandons bus transactions that exceed a timeout.

## Interface
- ADDR_W, 32, byte-address width on the core and bus side; must be ≥ 3.
- TIMEOUT_CYCLES, 255, maximum cycles spent in REQ+WAIT before abort; 0 disables the timeout.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  core presents an access.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign code.
- req_addr  in  ADDR_W  byte address (rs1 + offset, already summed).
- req_wdata  in  32  store data (rs2).
- req_rd  in  5  load destination register, echoed back.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_rd  out  5  echoed req_rd.
- resp_err  out  1  qualifies resp_valid: illegal, misaligned or timeout.
- mem_req  out  1  bus request, held until mem_gnt.
- mem_gnt  in  1  bus accepts the request this cycle.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_W  word-aligned address {req_addr[ADDR_W-1:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_rvalid  in  1  response or write acknowledge.
- mem_rdata  in  32  read word.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: if req_valid && req_ready, register all request fields.
  - Legal access: go to REQ.
  - Illegal or misaligned access: go to DONE with err=1; no bus activity.
- REQ: drive mem_req=1 and the mem_* fields, holding them stable until mem_gnt. On mem_gnt go to WAIT.
- WAIT: on mem_rvalid, capture mem_rdata and go to DONE.
- DONE: resp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value is illegal.
- Byte enables, with off = addr[1:0]:
  - Byte access: 4'b0001<<off.
  - Half-word access: 4'b0011<<{off[1],1'b0}.
  - Word access: 4'b1111.
- Store data: SB replicates the byte to all four lanes; SH replicates the half-word to both halves; SW passes the word unchanged.
- Load data:
  - Shift mem_rdata right by 8×off (half-word accesses use {off[1],0}).
  - Then sign-extend (LB/LH) or zero-extend (LBU/LHU).
- Timeout counter: cleared on entry to REQ and incremented each cycle in REQ/WAIT. When it reaches TIMEOUT_CYCLES, drop mem_req and go to DONE with err=1.
- mem_rvalid and mem_gnt are ignored outside REQ and WAIT; late responses are discarded.
- Simultaneous timeout and mem_rvalid in the same cycle: mem_rvalid wins, and the response has err=0.

## Timing
- Reset values: every output is 0 except req_ready=1. The FSM enters IDLE and the counter clears.
- Reset asserted mid-transaction abandons it immediately. No resp_valid is produced for the abandoned access.
- Accept at edge 0. mem_req is registered and high from cycle 1.
- Best-case latency, with mem_gnt in cycle 1 and mem_rvalid in cycle 2: resp_valid in cycle 3.
- Error without bus access: resp_valid in cycle 1.
- req_ready is low from cycle 1 until the cycle after resp_valid, so at most one access is outstanding.

## Configuration
- MJ32_LSU_MISALIGN_TRAP_EN defined:
  - Half-word access with addr[0]=1 is misaligned.
  - Word access with addr[1:0]≠0 is misaligned.
  - A misaligned access completes with err=1 and no bus request.
- Undefined:
  - Low address bits below the access size are ignored: half-word accesses treat off[0]=0, word accesses treat off=0.
  - No misalign error is ever raised.

## Test plan
- LB at 0x103, mem_gnt in cycle 1, mem_rvalid in cycle 2 with rdata 0x80FF_1234 -> mem_be=4'b1000; resp in cycle 3 with rdata=0xFFFF_FF80, err=0, resp_rd echoed.
- SH at 0x202, wdata 0xDEAD_BEEF, mem_gnt delayed 4 cycles -> mem_req and mem_addr=0x200 held stable; mem_be=4'b1100, mem_wdata=0xBEEF_BEEF, mem_we=1; resp rdata=0.
- LHU at 0x106 with rdata 0x8001_0000 -> resp rdata=0x0000_8001.
- LW at 0x101 -> with the macro: resp_err=1 in cycle 1 and mem_req never asserted. Without the macro: mem_addr=0x100, mem_be=4'hF, normal completion.
- TIMEOUT_CYCLES=8 with mem_gnt never asserted -> mem_req drops after 8 cycles; resp_valid=1 with err=1; a later mem_rvalid is ignored. Repeat with mem_rvalid in the terminal cycle -> err=0.
- funct3=3'b011 load -> err in cycle 1. Separately, assert reset in WAIT -> all outputs return to reset values, req_ready=1, and no response is produced.
